gbc_gamepak_bus_sequencer: RTL

//  Physical GamePak bus sequencer sitting directly downstream of GBCCartridgeController's GamePak port.

---
 rtl/gbc_gamepak_bus_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gbc_gamepak_bus_sequencer.sv
// GamePak bus sequencer: turns single-byte memory-port requests into timed cartridge bus cycles.
// Every phase is measured in ClkEn ticks, so a slowed reference clock stretches the bus cycle.
module gbc_gamepak_bus_sequencer #(
  parameter int unsigned SetupTicks     = 1,
  parameter int unsigned StrobeTicks    = 2,
  parameter int unsigned HoldTicks      = 1,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned ResetHoldTicks = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ClkEn,
  input  logic        Access,
  input  logic        Write,
  input  logic [15:0] Address,
  input  logic [7:0]  DInitiator,
  output logic [7:0]  DTarget,
  output logic        Ready,
  output logic        DataReady,
  output logic        CartClk,
  output logic        CartCs_n,
  output logic        CartRd_n,
  output logic        CartWr_n,
  output logic [15:0] CartAddr,
  output logic [7:0]  CartDataOut,
  output logic        CartDataOe,
  input  logic [7:0]  CartDataIn,
  output logic        CartReset_n
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxTicks =
    max2(max2(SetupTicks, StrobeTicks), max2(HoldTicks, ResetHoldTicks));
  localparam int unsigned CntW = $clog2(MaxTicks) + 1;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [7:0]        dtarget_q, dtarget_d;
  logic              ready_q, ready_d;
  logic              dready_q, dready_d;
  logic              cclk_q, cclk_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              crst_n_q, crst_n_d;
  logic [7:0]        sync_q [SyncStages];
  int unsigned       limit;
  logic              last_tick;

  // Pad data is asynchronous; the chain runs every Clk so it is settled before the strobe ends.
  always_ff @(posedge Clk) begin
    sync_q[0] <= CartDataIn;
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    case (state_q)
      RST_HOLD: limit = ResetHoldTicks;
      SETUP:    limit = SetupTicks;
      STROBE:   limit = StrobeTicks;
      HOLD:     limit = HoldTicks;
      default:  limit = 1;
    endcase
    last_tick = (cnt_q == CntW'(limit - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    dtarget_d = dtarget_q;
    ready_d   = ready_q;
    dready_d  = dready_q;
    cclk_d    = cclk_q;
    cs_n_d    = cs_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    crst_n_d  = crst_n_q;

    if (ClkEn) begin
      if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
      case (state_q)
        RST_HOLD: begin
          if (last_tick) begin
            state_d  = IDLE;
            cnt_d    = '0;
            crst_n_d = 1'b1;
            ready_d  = 1'b1;
          end
        end
        IDLE: begin
          if (Access) begin
            state_d = SETUP;
            cnt_d   = '0;
            wr_d    = Write;
            ready_d = 1'b0;
            addr_d  = Address;
            cs_n_d  = !((Address >= 16'hA000) && (Address <= 16'hFDFF));
            if (Write) begin
              dout_d = DInitiator;
              oe_d   = 1'b1;
            end else begin
              dready_d = 1'b0;
            end
          end
        end
        SETUP: begin
          if (last_tick) begin
            state_d = STROBE;
            cnt_d   = '0;
            cclk_d  = 1'b1;
            rd_n_d  = wr_q;
            wr_n_d  = !wr_q;
          end
        end
        STROBE: begin
          if (last_tick) begin
            state_d = HOLD;
            cnt_d   = '0;
            cclk_d  = 1'b0;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            if (!wr_q) begin
              dtarget_d = sync_q[SyncStages-1];
              dready_d  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (last_tick) begin
            state_d = IDLE;
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            oe_d    = 1'b0;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = RST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      dtarget_q <= '0;
      ready_q   <= 1'b0;
      dready_q  <= 1'b1;
      cclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      addr_q    <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      crst_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      dtarget_q <= dtarget_d;
      ready_q   <= ready_d;
      dready_q  <= dready_d;
      cclk_q    <= cclk_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      crst_n_q  <= crst_n_d;
    end
  end

  assign DTarget     = dtarget_q;
  assign Ready       = ready_q;
  assign DataReady   = dready_q;
  assign CartClk     = cclk_q;
  assign CartCs_n    = cs_n_q;
  assign CartRd_n    = rd_n_q;
  assign CartWr_n    = wr_n_q;
  assign CartAddr    = addr_q;
  assign CartDataOut = dout_q;
  assign CartDataOe  = oe_q;
  assign CartReset_n = crst_n_q;

endmodule
